pb_inject_sched: RTL and testbench

//  Schedules pushbutton-driven instruction injection into the fetch stage.

---
 rtl/pb_inject_sched_if.sv | 24 ++
 rtl/pb_inject_sched.sv | 141 ++++++++++++++
 tb/tb_pb_inject_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pb_inject_sched_if.sv
// Pin bundle between the board-facing button side and the pushbutton inject scheduler.
// master drives the raw buttons and pipeline status; slave is the scheduler.
interface pb_inject_sched_if;
    logic       pb1_raw;
    logic       pb2_raw;
    logic       stall;
    logic       redirect;
    logic       pb1_inj;
    logic       pb2_inj;
    logic       busy;
    logic [1:0] pend1;
    logic [1:0] pend2;
    logic [7:0] drop_cnt;

    modport master (
        output pb1_raw, pb2_raw, stall, redirect,
        input  pb1_inj, pb2_inj, busy, pend1, pend2, drop_cnt
    );

    modport slave (
        input  pb1_raw, pb2_raw, stall, redirect,
        output pb1_inj, pb2_inj, busy, pend1, pend2, drop_cnt
    );
endinterface

// File: rtl/pb_inject_sched.sv
// Debounces two pushbuttons, queues their presses and injects them into fetch
// one at a time, round-robin, only on cycles where fetch is free to take them.
module pb_inject_sched #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int QDEPTH      = 3,
    parameter int GAP         = 4
) (
    input  logic                clock,
    input  logic                aclr,
    pb_inject_sched_if.slave    bus
);
    localparam int         CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int         GAP_W = $clog2(GAP + 1);
    localparam logic [1:0] QMAX  = 2'(QDEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_INJECT, ST_GAP} state_t;

    logic [SYNC_STAGES-1:0] sync_q    [2];
    logic [CNT_W-1:0]       deb_cnt_q [2];
    logic [1:0]             pend_q    [2];
    logic [1:0]             deb_lvl_q;
    logic [1:0]             deb_prev_q;
    logic [1:0]             raw;
    logic [1:0]             press;
    logic [1:0]             inj;
    logic [1:0]             drop;
    logic [7:0]             drop_cnt_q;
    logic [8:0]             drop_sum;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;   // 0 = button 1, 1 = button 2
    logic             last_q, last_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    assign raw   = {bus.pb2_raw, bus.pb1_raw};
    assign press = deb_lvl_q & ~deb_prev_q;

    // Synchronise, then flip the debounced level only after DEB_CYCLES
    // consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (aclr) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i]    <= '0;
                deb_cnt_q[i] <= '0;
            end
            deb_lvl_q  <= '0;
            deb_prev_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                if (sync_q[i][SYNC_STAGES-1] != deb_lvl_q[i]) begin
                    if (deb_cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
                        deb_lvl_q[i] <= ~deb_lvl_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
            deb_prev_q <= deb_lvl_q;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        gap_d   = gap_q;
        inj     = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (pend_q[0] != 2'd0 || pend_q[1] != 2'd0) begin
                    state_d = ST_INJECT;
                    if (pend_q[0] != 2'd0 && pend_q[1] != 2'd0)
                        grant_d = ~last_q;
                    else
                        grant_d = (pend_q[1] != 2'd0);
                end
            end
            ST_INJECT: begin
                if (!bus.stall && !bus.redirect) begin
                    inj     = grant_q ? 2'b10 : 2'b01;
                    last_d  = grant_q;
                    gap_d   = GAP_W'(GAP - 1);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // The IDLE arbitration cycle is the last of the GAP quiet cycles.
                if (gap_q <= GAP_W'(1))
                    state_d = ST_IDLE;
                else
                    gap_d = gap_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A press on a full queue is lost unless the same cycle's injection frees a slot.
    always_comb begin
        drop = 2'b00;
        for (int i = 0; i < 2; i++)
            drop[i] = press[i] && !inj[i] && (pend_q[i] == QMAX);
        drop_sum = {1'b0, drop_cnt_q} + 9'(drop[0]) + 9'(drop[1]);
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            gap_q      <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < 2; i++)
                pend_q[i] <= 2'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            gap_q      <= gap_d;
            drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            for (int i = 0; i < 2; i++) begin
                if (press[i] && !inj[i] && pend_q[i] != QMAX)
                    pend_q[i] <= pend_q[i] + 1'b1;
                else if (inj[i] && !press[i])
                    pend_q[i] <= pend_q[i] - 1'b1;
            end
        end
    end

    assign bus.pb1_inj  = inj[0];
    assign bus.pb2_inj  = inj[1];
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.pend1    = pend_q[0];
    assign bus.pend2    = pend_q[1];
    assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_pb_inject_sched.sv
// Directed bench for pb_inject_sched: debounce latency, glitch rejection,
// round-robin ordering, queue saturation, stall/redirect retry and reset.
module tb_pb_inject_sched;
    logic clock;
    logic aclr;
    int   n_cmp;
    int   n_fail;
    int   cyc;
    int   overlap;
    int   peak1;
    int   peak2;
    int   log_btn[$];
    int   log_cyc[$];

    pb_inject_sched_if bus();

    pb_inject_sched dut (
        .clock (clock),
        .aclr  (aclr),
        .bus   (bus)
    );

    typedef struct {
        logic       stall;
        logic       redirect;
        logic       exp_inj1;
        logic       exp_inj2;
        logic [1:0] exp_pend1;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [10];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.pb1_inj && bus.pb2_inj) overlap = overlap + 1;
        if (bus.pb1_inj) begin log_btn.push_back(1); log_cyc.push_back(cyc); end
        if (bus.pb2_inj) begin log_btn.push_back(2); log_cyc.push_back(cyc); end
        if (int'(bus.pend1) > peak1) peak1 = int'(bus.pend1);
        if (int'(bus.pend2) > peak2) peak2 = int'(bus.pend2);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_log();
        log_btn.delete();
        log_cyc.delete();
        peak1 = 0;
        peak2 = 0;
    endtask

    task automatic do_reset();
        bus.pb1_raw  = 1'b0;
        bus.pb2_raw  = 1'b0;
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        aclr         = 1'b1;
        tick(2);
        aclr = 1'b0;
    endtask

    // btn: 1, 2, or 3 for both; held long enough to debounce both edges.
    task automatic press(input int btn);
        bus.pb1_raw = btn[0];
        bus.pb2_raw = btn[1];
        tick(24);
        bus.pb1_raw = 1'b0;
        bus.pb2_raw = 1'b0;
        tick(24);
    endtask

    initial begin
        int exp_order[4];
        int c0;
        int found;
        exp_order = '{1, 2, 1, 2};
        n_cmp   = 0;
        n_fail  = 0;
        cyc     = 0;
        overlap = 0;
        peak1   = 0;
        peak2   = 0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

        // Reset state, then a long press on button 1.
        do_reset();
        @(negedge clock);
        check("reset_busy",  int'(bus.busy),     0);
        check("reset_pend1", int'(bus.pend1),    0);
        check("reset_pend2", int'(bus.pend2),    0);
        check("reset_drop",  int'(bus.drop_cnt), 0);
        check("reset_inj",   int'({bus.pb1_inj, bus.pb2_inj}), 0);
        @(posedge clock); #1;
        clear_log();
        c0 = cyc;
        bus.pb1_raw = 1'b1;
        tick(40);
        bus.pb1_raw = 1'b0;
        tick(24);
        check("t1_pulses", log_btn.size(), 1);
        if (log_btn.size() == 1) begin
            check("t1_button",  log_btn[0], 1);
            check("t1_latency", log_cyc[0] - c0, 20);
        end
        check("t1_pend1_peak", peak1, 1);
        check("t1_pend1_end",  int'(bus.pend1), 0);
        check("t1_drop",       int'(bus.drop_cnt), 0);

        // Short glitch on button 2 must be filtered out.
        do_reset();
        clear_log();
        bus.pb2_raw = 1'b1;
        tick(10);
        bus.pb2_raw = 1'b0;
        tick(30);
        check("t2_pulses",     log_btn.size(), 0);
        check("t2_pend2_peak", peak2, 0);

        // Two presses on each button under stall, then round-robin release.
        do_reset();
        bus.stall = 1'b1;
        press(3);
        press(3);
        check("t3_pend1_q", int'(bus.pend1), 2);
        check("t3_pend2_q", int'(bus.pend2), 2);
        check("t3_busy_q",  int'(bus.busy),  1);
        clear_log();
        bus.stall = 1'b0;
        tick(40);
        check("t3_pulses", log_btn.size(), 4);
        if (log_btn.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("t3_order%0d", i), log_btn[i], exp_order[i]);
            for (int i = 1; i < 4; i++)
                check($sformatf("t3_space%0d", i), log_cyc[i] - log_cyc[i-1], 5);
        end
        check("t3_pend1_end", int'(bus.pend1), 0);
        check("t3_pend2_end", int'(bus.pend2), 0);

        // Five presses on a full queue under permanent stall.
        do_reset();
        bus.stall = 1'b1;
        clear_log();
        for (int i = 0; i < 5; i++) press(1);
        check("t4_pend1",  int'(bus.pend1),    3);
        check("t4_drop",   int'(bus.drop_cnt), 2);
        check("t4_busy",   int'(bus.busy),     1);
        check("t4_pulses", log_btn.size(),     0);

        // Table: stall/redirect retry in INJECT, then the GAP and IDLE cycles.
        do_reset();
        bus.stall = 1'b1;
        press(1);
        for (int i = 0; i < 10; i++) begin
            bus.stall    = vecs[i].stall;
            bus.redirect = vecs[i].redirect;
            @(negedge clock);
            check($sformatf("t5_inj1_%0d", i),  int'(bus.pb1_inj), int'(vecs[i].exp_inj1));
            check($sformatf("t5_inj2_%0d", i),  int'(bus.pb2_inj), int'(vecs[i].exp_inj2));
            check($sformatf("t5_pend1_%0d", i), int'(bus.pend1),   int'(vecs[i].exp_pend1));
            check($sformatf("t5_busy_%0d", i),  int'(bus.busy),    int'(vecs[i].exp_busy));
            @(posedge clock); #1;
        end

        // Reset in GAP with two presses still queued on button 2.
        do_reset();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) press(2);
        check("t6_pend2_q", int'(bus.pend2), 3);
        bus.stall = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clock);
            if (bus.pb2_inj) found = 1;
            @(posedge clock); #1;
        end
        check("t6_inj_seen",  found, 1);
        check("t6_pend2_gap", int'(bus.pend2), 2);
        check("t6_busy_gap",  int'(bus.busy),  1);
        aclr = 1'b1;
        tick(1);
        aclr = 1'b0;
        @(negedge clock);
        check("t6_busy_rst",  int'(bus.busy),  0);
        check("t6_pend1_rst", int'(bus.pend1), 0);
        check("t6_pend2_rst", int'(bus.pend2), 0);
        clear_log();
        tick(30);
        check("t6_no_inj", log_btn.size(), 0);

        check("never_both_inj", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
